mem_access_stage: RTL and testbench

Memory-access stage directly downstream of the EX/MEM pipeline register. It consumes the EX/MEM outputs: control bits, ALU result as address, store data and destination register. It performs the data-memory load/store over a req/ack bus and delivers registered results to the MEM/WB register. It asserts a stall back to EX/MEM and earlier stages while a memory access is outstanding.

---
 rtl/mem_access_stage.sv | 221 ++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Purpose  : Memory-access pipeline stage between EX/MEM and MEM/WB.
//            Non-memory instructions pass through in one cycle. Loads and
//            stores are issued on a req/ack data bus. Upstream stages are
//            stalled while the access is outstanding. An access that sees no
//            ack within TIMEOUT_CYCLES is aborted with a bus_error pulse.
// Params   : TIMEOUT_CYCLES - cycles mem_req may stay high without mem_ack
//                             (legal range 2..255)
// Macro    : MEM_MISALIGN_TRAP_EN - when defined, a memory op whose address
//            has AluOut[2:0] != 0 is not issued on the bus. It retires next
//            cycle with a misalign pulse. When undefined, misalign is tied
//            to 0.
// Ports    : clk, reset (sync, active-high)
//            EX/MEM in : valid_in, RegWrite, MemtoReg, MemWrite,
//                        AluOut, DataOut, Rd_in
//            stall     : combinational hold request to upstream stages
//            bus       : mem_req, mem_we, mem_addr, mem_wdata (out),
//                        mem_rdata, mem_ack (in)
//            MEM/WB out: valid_out, RegWrite_Out, MemtoReg_Out, ReadData,
//                        AluResult_Out, Rd_out, bus_error, misalign
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  input  logic        MemWrite,
  input  logic [63:0] AluOut,
  input  logic [63:0] DataOut,
  input  logic [4:0]  Rd_in,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ack,
  output logic        valid_out,
  output logic        RegWrite_Out,
  output logic        MemtoReg_Out,
  output logic [63:0] ReadData,
  output logic [63:0] AluResult_Out,
  output logic [4:0]  Rd_out,
  output logic        bus_error,
  output logic        misalign
);

  localparam logic [7:0] c_to_last = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;

  logic        r_mem_req;
  logic        r_mem_we;
  logic [63:0] r_mem_addr;
  logic [63:0] r_mem_wdata;

  // Latched control of the outstanding access
  logic        r_l_rw;
  logic        r_l_m2r;
  logic [4:0]  r_l_rd;

  logic        r_valid_out;
  logic        r_rw_out;
  logic        r_m2r_out;
  logic [63:0] r_read_data;
  logic [63:0] r_alu_out;
  logic [4:0]  r_rd_out;
  logic        r_bus_err;
  logic        r_mis;

  logic        w_mem_op;
  logic        w_mis;
  logic        w_issue;
  logic        w_timeout;

  assign w_mem_op = valid_in & (MemWrite | MemtoReg);

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_mis = w_mem_op & (|AluOut[2:0]);
`else
  assign w_mis = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and stall. Stall drops in the ack/timeout cycle so that
  // EX/MEM advances on the same edge that retires the access.
  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    w_issue     = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_mem_op && !w_mis) begin
          w_issue     = 1'b1;
          stall       = 1'b1;
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // An ack in the last allowed cycle takes priority over the timeout
        w_timeout = ~mem_ack & (r_cnt == c_to_last);
        if (mem_ack || w_timeout) begin
          w_state_nxt = S_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus side and MEM/WB payload registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= 8'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 64'd0;
      r_mem_wdata <= 64'd0;
      r_l_rw      <= 1'b0;
      r_l_m2r     <= 1'b0;
      r_l_rd      <= 5'd0;
      r_valid_out <= 1'b0;
      r_rw_out    <= 1'b0;
      r_m2r_out   <= 1'b0;
      r_read_data <= 64'd0;
      r_alu_out   <= 64'd0;
      r_rd_out    <= 5'd0;
      r_bus_err   <= 1'b0;
      r_mis       <= 1'b0;
    end else begin
      // Pulse-type outputs default low; data outputs hold
      r_valid_out <= 1'b0;
      r_rw_out    <= 1'b0;
      r_m2r_out   <= 1'b0;
      r_bus_err   <= 1'b0;
      r_mis       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= MemWrite;
            r_mem_addr  <= AluOut;
            r_mem_wdata <= DataOut;
            r_l_rw      <= RegWrite;
            // Both MemWrite and MemtoReg set is a store: no load write-back
            r_l_m2r     <= MemtoReg & ~MemWrite;
            r_l_rd      <= Rd_in;
            r_cnt       <= 8'd0;
          end else if (valid_in) begin
            // ALU pass-through, or a trapped misaligned memory op
            r_valid_out <= 1'b1;
            r_rw_out    <= RegWrite & ~w_mis & (Rd_in != 5'd0);
            r_alu_out   <= AluOut;
            r_rd_out    <= Rd_in;
            r_mis       <= w_mis;
          end
        end
        S_ACCESS: begin
          if (mem_ack) begin
            r_mem_req   <= 1'b0;
            r_valid_out <= 1'b1;
            r_rw_out    <= r_l_rw & (r_l_rd != 5'd0);
            r_m2r_out   <= r_l_m2r;
            if (!r_mem_we) begin
              r_read_data <= mem_rdata;
            end
            r_alu_out   <= r_mem_addr;
            r_rd_out    <= r_l_rd;
          end else if (w_timeout) begin
            r_mem_req   <= 1'b0;
            r_valid_out <= 1'b1;
            r_bus_err   <= 1'b1;
            r_alu_out   <= r_mem_addr;
            r_rd_out    <= r_l_rd;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req       = r_mem_req;
  assign mem_we        = r_mem_we;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign valid_out     = r_valid_out;
  assign RegWrite_Out  = r_rw_out;
  assign MemtoReg_Out  = r_m2r_out;
  assign ReadData      = r_read_data;
  assign AluResult_Out = r_alu_out;
  assign Rd_out        = r_rd_out;
  assign bus_error     = r_bus_err;
  assign misalign      = r_mis;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_stage
// Purpose  : Self-checking bench for mem_access_stage. Directed scenarios are
//            followed by random instructions; a transaction-level model
//            predicts stall length, bus activity and the retired payload.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in, RegWrite, MemtoReg, MemWrite;
  logic [63:0] AluOut, DataOut;
  logic [4:0]  Rd_in;
  logic        stall, mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        valid_out, RegWrite_Out, MemtoReg_Out;
  logic [63:0] ReadData, AluResult_Out;
  logic [4:0]  Rd_out;
  logic        bus_error, misalign;

  int checks = 0;
  int errors = 0;

  // Model of the held data outputs
  logic [63:0] m_read_data;
  logic [63:0] m_alu;
  logic [4:0]  m_rd;
  bit          m_known;

  mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .MemWrite(MemWrite), .AluOut(AluOut),
    .DataOut(DataOut), .Rd_in(Rd_in), .stall(stall), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .valid_out(valid_out),
    .RegWrite_Out(RegWrite_Out), .MemtoReg_Out(MemtoReg_Out),
    .ReadData(ReadData), .AluResult_Out(AluResult_Out), .Rd_out(Rd_out),
    .bus_error(bus_error), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".mem_req"}, mem_req, 0);
    chk({tag, ".mem_we"}, mem_we, 0);
    chk({tag, ".mem_addr"}, mem_addr, 0);
    chk({tag, ".mem_wdata"}, mem_wdata, 0);
    chk({tag, ".valid_out"}, valid_out, 0);
    chk({tag, ".RegWrite_Out"}, RegWrite_Out, 0);
    chk({tag, ".MemtoReg_Out"}, MemtoReg_Out, 0);
    chk({tag, ".ReadData"}, ReadData, 0);
    chk({tag, ".AluResult_Out"}, AluResult_Out, 0);
    chk({tag, ".Rd_out"}, Rd_out, 0);
    chk({tag, ".bus_error"}, bus_error, 0);
    chk({tag, ".misalign"}, misalign, 0);
    chk({tag, ".stall"}, stall, 0);
  endtask

  // Present one instruction (entered just after a rising edge), act as the
  // bus slave acking in ACCESS cycle ack_dly (>= TO means never), and check
  // the retired payload right after the completing edge.
  task automatic do_op(input string tag, input logic v, input logic rw,
                       input logic m2r, input logic mw, input logic [63:0] addr,
                       input logic [63:0] wd, input logic [4:0] rd,
                       input int ack_dly, input logic [63:0] rdat);
    bit mem_op, mis, bus, acked, done, s;
    int exp_cyc, nstall, nreq, k, cyc, vo_mid;
    logic req_we;
    logic [63:0] req_addr, req_wd;

    valid_in = v; RegWrite = rw; MemtoReg = m2r; MemWrite = mw;
    AluOut = addr; DataOut = wd; Rd_in = rd;

    mem_op = v && (mw || m2r);
`ifdef MEM_MISALIGN_TRAP_EN
    mis = mem_op && (addr[2:0] != 3'b000);
`else
    mis = 1'b0;
`endif
    bus     = mem_op && !mis;
    acked   = ack_dly < TO;
    exp_cyc = !bus ? 0 : (acked ? ack_dly + 1 : TO);

    nstall = 0; nreq = 0; k = 0; cyc = 0; vo_mid = 0; done = 0;
    req_we = 1'b0; req_addr = '0; req_wd = '0;
    while (!done && cyc < 64) begin
      @(negedge clk);
      if (mem_req) begin
        if (k == 0) begin
          req_we = mem_we; req_addr = mem_addr; req_wd = mem_wdata;
        end
        if (k == ack_dly) begin
          mem_ack = 1'b1;
          mem_rdata = rdat;
        end
        k++;
        nreq++;
      end
      #1;
      s = stall;
      if (s) nstall++;
      if (cyc > 0 && valid_out) vo_mid++;
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      mem_rdata = {$urandom, $urandom};
      cyc++;
      if (!s) done = 1;
    end
    chk({tag, ".completes_in_bound"}, done, 1);

    chk({tag, ".stall_cycles"}, nstall, exp_cyc);
    chk({tag, ".req_cycles"}, nreq, exp_cyc);
    chk({tag, ".valid_mid_access"}, vo_mid, 0);
    if (bus) begin
      chk({tag, ".mem_we"}, req_we, mw);
      chk({tag, ".mem_addr"}, req_addr, addr);
      if (mw) chk({tag, ".mem_wdata"}, req_wd, wd);
    end

    chk({tag, ".valid_out"}, valid_out, v);
    chk({tag, ".bus_error"}, bus_error, bus && !acked);
    chk({tag, ".misalign"}, misalign, mis);
    if (v) begin
      chk({tag, ".RegWrite_Out"}, RegWrite_Out,
          rw && (rd != 5'd0) && !mis && !(bus && !acked));
      if (!(bus && !acked)) begin
        chk({tag, ".MemtoReg_Out"}, MemtoReg_Out, bus && m2r && !mw);
        chk({tag, ".AluResult_Out"}, AluResult_Out, addr);
        chk({tag, ".Rd_out"}, Rd_out, rd);
        m_known = 1;
      end else begin
        m_known = 0;
      end
      m_alu = addr;
      m_rd  = rd;
      if (bus && acked && !mw) m_read_data = rdat;
    end else begin
      chk({tag, ".RegWrite_Out"}, RegWrite_Out, 0);
      chk({tag, ".MemtoReg_Out"}, MemtoReg_Out, 0);
      if (m_known) begin
        chk({tag, ".AluResult_hold"}, AluResult_Out, m_alu);
        chk({tag, ".Rd_hold"}, Rd_out, m_rd);
      end
    end
    chk({tag, ".ReadData"}, ReadData, m_read_data);

    valid_in = 1'b0;
  endtask

  initial begin
    logic [63:0] a;
    reset = 1'b1; valid_in = 1'b0; RegWrite = 1'b0; MemtoReg = 1'b0;
    MemWrite = 1'b0; AluOut = '0; DataOut = '0; Rd_in = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    m_read_data = '0; m_alu = '0; m_rd = '0; m_known = 1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;

    // ALU op: one-cycle pass-through, no stall
    do_op("alu", 1, 1, 0, 0, 64'h1234, 64'h0, 5'd5, 0, 64'h0);
    // Load acked in the fourth ACCESS cycle
    do_op("load", 1, 1, 1, 0, 64'h100, 64'h0, 5'd7, 3, 64'hDEADBEEF);
    do_op("idle1", 0, 0, 0, 0, 64'h0, 64'h0, 5'd0, 0, 64'h0);
    // Store never acked: timeout
    do_op("store_to", 1, 1, 0, 1, 64'h40, 64'hCAFE, 5'd2, 1000, 64'h0);
    do_op("idle2", 0, 0, 0, 0, 64'h0, 64'h0, 5'd0, 0, 64'h0);
    // Ack in the very last allowed cycle beats the timeout
    do_op("ack_last", 1, 1, 1, 0, 64'h208, 64'h0, 5'd11, TO - 1, 64'h55AA);
    // Both MemWrite and MemtoReg set: treated as a store
    do_op("both", 1, 1, 1, 1, 64'h300, 64'h77, 5'd12, 1, 64'h9999);
    // Back-to-back load then ALU op writing x0
    do_op("b2b_load", 1, 1, 1, 0, 64'h108, 64'h0, 5'd9, 0, 64'h1122334455667788);
    do_op("b2b_alu", 1, 1, 0, 0, 64'h4242, 64'h0, 5'd0, 0, 64'h0);
    // Misaligned load (trapped only when the feature is built in)
    do_op("misalign", 1, 1, 1, 0, 64'h103, 64'h0, 5'd4, 2, 64'hABCD);
    do_op("idle3", 0, 0, 0, 0, 64'h0, 64'h0, 5'd0, 0, 64'h0);

    // Reset during an outstanding access, then a late ack
    valid_in = 1'b1; RegWrite = 1'b1; MemtoReg = 1'b1; MemWrite = 1'b0;
    AluOut = 64'h200; Rd_in = 5'd3;
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(posedge clk); #1;
    chk("midrst.req_before", mem_req, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 64'hBAD0BAD0;
    @(negedge clk);
    chk("midrst.late_ack_stall", stall, 0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("midrst.late_ack_valid", valid_out, 0);
    chk("midrst.late_ack_rdata", ReadData, 0);
    chk("midrst.late_ack_req", mem_req, 0);
    m_read_data = '0; m_alu = '0; m_rd = '0; m_known = 1;

    // Random instruction stream
    for (int i = 0; i < 40; i++) begin
      a = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) a[2:0] = 3'b000;
      do_op($sformatf("rnd%0d", i), $urandom_range(0, 3) != 0,
            1'($urandom), 1'($urandom), 1'($urandom), a,
            {$urandom, $urandom}, 5'($urandom),
            int'($urandom_range(0, TO + 3)), {$urandom, $urandom});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
